// File: rtl/k2_pkg.sv
// Shared types and constants for the K2 result-bus UART logger.
package k2_pkg;

    // Serialiser states; encoding is exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/ro_fifo.sv
// Small synchronous FIFO. The head entry is presented combinationally on dout
// whenever the FIFO is not empty. A push while full is accepted only when a
// pop frees a slot on the same edge; otherwise it is ignored.
module ro_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;

    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == LW'(DEPTH));
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ro_uart_logger.sv
// Watches the processor result bus, queues every new value and sends each one
// off-chip as an 8N1 UART frame (LSB first). Never stalls the processor: when
// the queue is full a new value is dropped and a sticky overflow flag is set.
module ro_uart_logger
    import k2_pkg::*;
#(
    parameter int bits         = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [bits-1:0]            Ro,
    output logic                       tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output uart_state_t                o_dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW = $clog2(DEPTH+1);

    // Change detector
    logic [bits-1:0]           r_last_ro;
    logic                      w_push_req;
    logic [UART_DATA_BITS-1:0] w_din;

    // FIFO interface
    logic [UART_DATA_BITS-1:0] w_dout;
    logic                      w_full;
    logic                      w_empty;
    logic [LW-1:0]             w_level;
    logic                      w_pop;

    // Serialiser state
    uart_state_t               r_state,  w_state_nx;
    logic [CW-1:0]             r_baud,   w_baud_nx;
    logic [2:0]                r_idx,    w_idx_nx;
    logic [UART_DATA_BITS-1:0] r_shift,  w_shift_nx;
    logic                      r_tx,     w_tx_nx;
    logic                      r_overflow;
    logic                      w_bit_end;

    assign w_push_req = (Ro != r_last_ro);
    assign w_din      = UART_DATA_BITS'(Ro);
    assign w_bit_end  = (r_baud == CW'(CLKS_PER_BIT-1));

    // Remember the last value seen so only changes are queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_ro <= '0;
        end else if (w_push_req) begin
            r_last_ro <= Ro;
        end
    end

    ro_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Sticky drop flag: a change arrived while full and nothing left this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Serialiser state register; tx resets high so the line idles asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= UART_STOP_BIT;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // Next-state logic; tx is computed one edge early so the line comes from a flop.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_tx_nx    = r_tx;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nx = '0;
                w_idx_nx  = '0;
                w_tx_nx   = UART_STOP_BIT;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_dout;
                    w_state_nx = START;
                    w_tx_nx    = UART_START_BIT;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_nx  = '0;
                    w_state_nx = DATA;
                    w_tx_nx    = r_shift[0];
                end else begin
                    w_baud_nx = r_baud + CW'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_nx = '0;
                    if (r_idx == 3'(UART_DATA_BITS-1)) begin
                        w_state_nx = STOP;
                        w_tx_nx    = UART_STOP_BIT;
                    end else begin
                        w_idx_nx   = r_idx + 3'd1;
                        w_shift_nx = r_shift >> 1;
                        w_tx_nx    = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud + CW'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_nx  = '0;
                    w_state_nx = IDLE;
                    w_tx_nx    = UART_STOP_BIT;
                end else begin
                    w_baud_nx = r_baud + CW'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_baud_nx  = '0;
                w_idx_nx   = '0;
                w_tx_nx    = UART_STOP_BIT;
            end
        endcase
    end

    assign tx          = r_tx;
    assign overflow    = r_overflow;
    assign level       = w_level;
    assign busy        = (r_state != IDLE) || (w_level != '0);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ro_uart_logger.sv
// Bench for ro_uart_logger with 4 clocks per bit and a 4-entry queue.
// A line monitor decodes frames and compares them against an expected queue
// filled by the stimulus driver.
module tb_ro_uart_logger;
    import k2_pkg::*;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  ro;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  level;
    uart_state_t dbg_state;

    logic [7:0]  exp_q[$];
    int          n_checks;
    int          n_fail;
    int          n_frames;

    ro_uart_logger #(
        .bits         (8),
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Ro          (ro),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .level       (level),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks (called at a negedge, return at the following negedge)
    task automatic drive_ro(input logic [7:0] v, input bit sent);
        ro = v;
        if (sent) exp_q.push_back(v);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ro  = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // line monitor: frame decode and scoreboard compare
    initial begin : monitor
        logic [7:0] data;
        logic       start_b;
        logic       stop_b;
        logic       aborted;
        logic [7:0] exp_v;
        n_frames = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                aborted = 1'b0;
                data    = '0;
                start_b = 1'b1;
                stop_b  = 1'b0;
                for (int s = 1; s <= 37; s++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                    if (s == 1) start_b = tx;
                    else if (s == 37) stop_b = tx;
                    else if (((s - 1) % 4) == 0) data[(s - 5) / 4] = tx;
                end
                if (!aborted) begin
                    n_frames++;
                    check("rx_start_bit", 32'(start_b), 32'd0);
                    check("rx_stop_bit", 32'(stop_b), 32'd1);
                    check("rx_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        check("rx_data", 32'(data), 32'(exp_v));
                    end
                end
            end
        end
    end

    // main stimulus
    initial begin : main
        logic [7:0] wave [40];
        logic [7:0] v5;
        int         peak;
        int         f0;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ro       = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;

        // Ro held at 0 after reset: nothing is ever sent
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_overflow", 32'(overflow), 32'd0);
            check("idle_level", 32'(level), 32'd0);
        end
        check("idle_frames", 32'(n_frames), 32'd0);

        // single value 0x05: exact line waveform
        v5 = 8'h05;
        for (int c = 0; c < 40; c++) begin
            if (c < 4)       wave[c] = 8'd0;
            else if (c < 36) wave[c] = 8'(v5[(c - 4) / 4]);
            else             wave[c] = 8'd1;
        end
        drive_ro(8'h05, 1'b1);
        check("single_level_after_push", 32'(level), 32'd1);
        check("single_tx_before_pop", 32'(tx), 32'd1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("single_tx_cycle%0d", c), 32'(tx), 32'(wave[c]));
        end
        check("single_busy_in_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_busy_after_stop", 32'(busy), 32'd0);
        check("single_state_idle", 32'(dbg_state), 32'(IDLE));

        // Ro held: no further frames
        repeat (100) @(negedge clk);
        check("hold_frames", 32'(n_frames), 32'd1);
        check("hold_queue_drained", 32'(exp_q.size()), 32'd0);

        // burst 1,2,3,5,8,13 on consecutive edges: 13 dropped
        peak = 0;
        drive_ro(8'h01, 1'b1); if (int'(level) > peak) peak = int'(level);
        drive_ro(8'h02, 1'b1); if (int'(level) > peak) peak = int'(level);
        drive_ro(8'h03, 1'b1); if (int'(level) > peak) peak = int'(level);
        drive_ro(8'h05, 1'b1); if (int'(level) > peak) peak = int'(level);
        drive_ro(8'h08, 1'b1); if (int'(level) > peak) peak = int'(level);
        check("burst_no_overflow_yet", 32'(overflow), 32'd0);
        drive_ro(8'h0D, 1'b0); if (int'(level) > peak) peak = int'(level);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_level_peak", 32'(peak), 32'd4);
        f0 = n_frames;
        repeat (260) @(negedge clk);
        check("burst_frames", 32'(n_frames - f0), 32'd5);
        check("burst_queue_drained", 32'(exp_q.size()), 32'd0);
        check("burst_overflow_sticky", 32'(overflow), 32'd1);

        // full queue, new value on the pop edge: accepted
        apply_reset();
        check("full_overflow_cleared", 32'(overflow), 32'd0);
        f0 = n_frames;
        drive_ro(8'h01, 1'b1);
        drive_ro(8'h02, 1'b1);
        drive_ro(8'h03, 1'b1);
        drive_ro(8'h05, 1'b1);
        drive_ro(8'h08, 1'b1);
        check("full_level4", 32'(level), 32'd4);
        repeat (37) @(negedge clk);
        check("full_state_idle_gap", 32'(dbg_state), 32'(IDLE));
        check("full_level_before_pop", 32'(level), 32'd4);
        drive_ro(8'h21, 1'b1);
        check("full_level_pop_push", 32'(level), 32'd4);
        check("full_no_overflow", 32'(overflow), 32'd0);
        check("full_state_start", 32'(dbg_state), 32'(START));
        repeat (260) @(negedge clk);
        check("full_frames", 32'(n_frames - f0), 32'd6);
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);
        check("full_overflow_final", 32'(overflow), 32'd0);

        // reset during DATA bit 3 with two values queued
        apply_reset();
        drive_ro(8'h11, 1'b1);
        drive_ro(8'h22, 1'b1);
        drive_ro(8'h33, 1'b1);
        check("midrst_level2", 32'(level), 32'd2);
        repeat (16) @(negedge clk);
        check("midrst_in_data", 32'(dbg_state), 32'(DATA));
        f0  = n_frames;
        rst = 1'b1;
        ro  = 8'h00;
        exp_q.delete();
        #1;
        check("midrst_tx_high", 32'(tx), 32'd1);
        check("midrst_level0", 32'(level), 32'd0);
        check("midrst_busy0", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_remnant", 32'(n_frames - f0), 32'd0);
        check("midrst_tx_idle", 32'(tx), 32'd1);
        check("midrst_busy_idle", 32'(busy), 32'd0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_uart_logger.md
# ro_uart_logger

Downstream consumer of the K2 processor's `Ro` result bus. The block watches `Ro` every cycle and queues each new value in a small FIFO. It then serialises the queued values as 8N1 UART frames on a single `tx` line, so a Fibonacci (or any) program's output sequence can be logged off-chip. It sits beside the processor/instruction-memory top and adds no back-pressure to the processor.

## Interface
- `bits`, 8: width of `Ro`; must be ≤ 8, zero-extended to 8 data bits on the line.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Ro`  in  bits  processor output value, sampled every rising edge.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a new value is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

## Operation
- Change detect: register `last_ro`, reset 0. On each edge, if `Ro != last_ro`, then `last_ro <= Ro` and a push is requested.
  - `Ro == 0` right after reset is therefore never sent.
  - Repeated equal values are never sent.
- FIFO: push writes `Ro`. A pop is issued by the FSM.
  - Simultaneous pop and push when full: the pop frees a slot and the push is accepted. `level` is unchanged and `overflow` is not set.
  - Push when full with no pop: the value is dropped and `overflow <= 1`. `last_ro` is still updated.
  - Simultaneous push and pop when empty cannot happen, because pop requires non-empty.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop into an 8-bit shift register and go to START. The baud counter and bit index are cleared.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx = shift[0]`, LSB first. Shift after each CLKS_PER_BIT cycles. After 8 bits, go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on a bit boundary. The 3-bit index counts 0..7 in DATA.
- `tx` is driven from a register, glitch-free.
- `busy = (state != IDLE) | (level != 0)`.
- `overflow` clears only on reset.

## Timing
- Reset values: `tx=1`, `busy=0`, `overflow=0`, `level=0`, state IDLE, `last_ro=0`, FIFO empty.
- Reset asserted mid-frame: `tx` returns high immediately (asynchronously). Queued data and the partial frame are discarded.
- Latency:
  - `Ro` changes before edge k.
  - At edge k, push; `level` increments after edge k.
  - At edge k+1, pop; `tx` falls after edge k+1.
- Frame length: 10×CLKS_PER_BIT cycles, plus at least 1 IDLE cycle before the next START.
- Throughput: one value per 10×CLKS_PER_BIT+1 cycles. Faster changes fill the FIFO.

## Structure
- Shared package `k2_pkg` holds:
  - the `uart_state_t` enum (IDLE, START, DATA, STOP);
  - constants `UART_START_BIT=0`, `UART_STOP_BIT=1`, `UART_DATA_BITS=8`.
- One sub-module, `ro_fifo`: synchronous FIFO with parameters width and `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`.
  - `dout` is valid combinationally when not empty.
- `ro_uart_logger` contains the change detector, the FSM and baud counter, and the `overflow` register.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `DEPTH=4`.
- Reset, and reset released with `Ro=0` held for 50 cycles → `tx=1`, `busy=0`, `overflow=0`, `level=0` throughout; no frame.
- `Ro` 0→0x05 → `level=1` after edge k. `tx`: low from edge k+1 for 4 cycles, then 1,0,1,0,0,0,0,0 for 4 cycles each, then high for 4 cycles. `busy` drops after STOP.
- `Ro` held at 0x05 for 100 cycles after the first frame → exactly one frame total.
- `Ro` stepping 1,2,3,5,8,13 on consecutive edges:
  - frames emitted, in order: 0x01, 0x02, 0x03, 0x05, 0x08;
  - 0x0D is dropped and `overflow=1` after the 6th edge;
  - `level` peaks at 4.
- FIFO full (level 4) while STOP ends, with a new `Ro` value on the same edge as the pop → push accepted, `level` stays 4, `overflow` stays 0, and the new value appears as the 5th subsequent frame.
- `rst` asserted during DATA bit 3 with 2 values queued → `tx=1` in the same cycle, `level=0`, `busy=0`. After release, no remnant frame is sent.
